// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode, ALU operation and FSM state constants shared by the sequencer.
package alu_seq_pkg;
  localparam logic [2:0] OP_AND32 = 3'b000;
  localparam logic [2:0] OP_OR32  = 3'b001;
  localparam logic [2:0] OP_ADD32 = 3'b010;
  localparam logic [2:0] OP_SUB32 = 3'b011;
  localparam logic [2:0] OP_ADD64 = 3'b110;
  localparam logic [2:0] OP_SUB64 = 3'b111;
  localparam logic [1:0] ALU_AND  = 2'b00;
  localparam logic [1:0] ALU_OR   = 2'b01;
  localparam logic [1:0] ALU_ADD  = 2'b10;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LO     = 2'd1;
  localparam logic [1:0] S_HI     = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: maps a command opcode to ALU controls, width and legality.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] op,
  output logic [1:0] operation,
  output logic       binvert,
  output logic       cin_lo,
  output logic       is64,
  output logic       illegal
);
  always_comb begin
    illegal   = (op == 3'b100) || (op == 3'b101);
    is64      = (op == OP_ADD64) || (op == OP_SUB64);
    binvert   = (op == OP_SUB32) || (op == OP_SUB64);
    cin_lo    = binvert;
    operation = illegal ? ALU_AND : op[1] ? ALU_ADD : op[0] ? ALU_OR : ALU_AND;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs 32/64-bit logic and add/sub commands over a shared 32-bit combinational ALU.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_a,
  input  logic [63:0] cmd_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_operation,
  output logic        alu_binvert,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_err
);
  logic [1:0]  state;
  logic [63:0] a_q, b_q;
  logic [1:0]  op_q;
  logic        inv_q, cin_q, is64_q, carry;
  logic [1:0]  d_op;
  logic        d_inv, d_cin, d_is64, d_ill;
  logic        lo, hi;
  alu_seq_decode u_decode (
    .op        (cmd_op),
    .operation (d_op),
    .binvert   (d_inv),
    .cin_lo    (d_cin),
    .is64      (d_is64),
    .illegal   (d_ill)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      inv_q    <= 1'b0;
      cin_q    <= 1'b0;
      is64_q   <= 1'b0;
      carry    <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          a_q    <= cmd_a;
          b_q    <= cmd_b;
          op_q   <= d_op;
          inv_q  <= d_inv;
          cin_q  <= d_cin;
          is64_q <= d_is64;
          if (d_ill) begin
            rsp_data <= '0;
            carry    <= 1'b0;
            rsp_zero <= 1'b1;
            rsp_err  <= 1'b1;
            state    <= S_RESP;
          end else begin
            rsp_err <= 1'b0;
            state   <= S_LO;
          end
        end
        S_LO: begin
          rsp_data <= {32'b0, alu_result};
          carry    <= (op_q == ALU_ADD) && alu_cout;
          rsp_zero <= alu_result == 32'b0;
          state    <= is64_q ? S_HI : S_RESP;
        end
        S_HI: begin
          rsp_data[63:32] <= alu_result;
          carry           <= alu_cout;
          rsp_zero        <= (alu_result == 32'b0) && (rsp_data[31:0] == 32'b0);
          state           <= S_RESP;
        end
        default: if (rsp_ready) state <= S_IDLE;
      endcase
    end
  end
  always_comb begin
    lo            = state == S_LO;
    hi            = state == S_HI;
    cmd_ready     = (state == S_IDLE) && !rst;
    rsp_valid     = state == S_RESP;
    rsp_carry     = carry;
    alu_a         = lo ? a_q[31:0] : hi ? a_q[63:32] : 32'b0;
    alu_b         = lo ? b_q[31:0] : hi ? b_q[63:32] : 32'b0;
    alu_operation = lo ? op_q : hi ? ALU_ADD : ALU_AND;
    alu_binvert   = (lo || hi) && inv_q;
    alu_cin       = lo ? cin_q : hi && carry;
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors against alu_sequencer with a behavioural 32-bit ALU.
module tb_alu_sequencer;
  logic        clk = 0, rst = 1;
  logic        cmd_valid = 0, cmd_ready;
  logic [2:0]  cmd_op = 0;
  logic [63:0] cmd_a = 0, cmd_b = 0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_operation;
  logic        alu_binvert, alu_cin, alu_cout;
  logic        rsp_valid, rsp_ready = 0;
  logic [63:0] rsp_data;
  logic        rsp_carry, rsp_zero, rsp_err;
  int          total = 0, bad = 0, lat;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_binvert(alu_binvert), .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic [32:0] sum;
    sum = {1'b0, alu_a} + {1'b0, alu_binvert ? ~alu_b : alu_b} + {32'b0, alu_cin};
    alu_result = alu_operation == 2'b00 ? alu_a & alu_b : alu_operation == 2'b01 ? alu_a | alu_b : sum[31:0];
    alu_cout   = alu_operation == 2'b10 ? sum[32] : 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int l);
    l = 1;
    while (!rsp_valid && l < 10) begin
      @(posedge clk);
      #1 l++;
    end
  endtask

  task automatic release_rsp;
    @(negedge clk);
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    chk("rsp_exit", {63'b0, rsp_valid}, 64'd0);
    chk("ready_after", {63'b0, cmd_ready}, 64'd1);
  endtask

  task automatic check_rsp(input string tag, input int exp_lat, input logic [63:0] data,
                           input logic carry, input logic zero, input logic err);
    wait_rsp(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, rsp_data, data);
    chk({tag, "_flags"}, {61'b0, rsp_carry, rsp_zero, rsp_err}, {61'b0, carry, zero, err});
  endtask

  initial begin
    #3;
    chk("rst_ready", {63'b0, cmd_ready}, 64'd0);
    chk("rst_outs", {rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err, alu_a, alu_b}, 64'd0);
    @(negedge clk) rst = 0;
    issue(3'b010, 64'hFFFF_FFFF, 64'd1);
    chk("add32_lo_ctl", {alu_operation, alu_binvert, alu_cin}, 64'b1000);
    chk("add32_lo_a", {32'b0, alu_a}, 64'hFFFF_FFFF);
    check_rsp("add32", 2, 64'd0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_data", rsp_data, 64'd0);
      chk("hold_state", {rsp_valid, cmd_ready, rsp_carry, rsp_zero, rsp_err}, 64'b10110);
      chk("hold_alu", {alu_a, alu_b} | {60'b0, alu_operation, alu_binvert, alu_cin}, 64'd0);
    end
    release_rsp();
    issue(3'b111, 64'h1_0000_0000, 64'd1);
    chk("sub64_lo_ctl", {alu_operation, alu_binvert, alu_cin}, 64'b1011);
    @(posedge clk) #1;
    chk("sub64_hi_ctl", {alu_operation, alu_binvert, alu_cin}, 64'b1010);
    chk("sub64_hi_a", {32'b0, alu_a}, 64'd1);
    check_rsp("sub64", 2, 64'h0000_0000_FFFF_FFFF, 1, 0, 0);
    release_rsp();
    issue(3'b110, 64'h0000_0000_FFFF_FFFF, 64'd1);
    @(posedge clk) #1;
    chk("add64_hi_cin", {62'b0, alu_binvert, alu_cin}, 64'b01);
    check_rsp("add64", 2, 64'h0000_0001_0000_0000, 0, 0, 0);
    release_rsp();
    issue(3'b000, 64'hDEAD_BEEF_FF00_FF00, 64'h1234_5678_0F0F_0F0F);
    chk("and_lo_ctl", {alu_operation, alu_binvert, alu_cin}, 64'b0000);
    check_rsp("and32", 2, 64'h0F00_0F00, 0, 0, 0);
    release_rsp();
    issue(3'b001, 64'h0000_F000, 64'h0000_000F);
    chk("or_lo_ctl", {alu_operation, alu_binvert, alu_cin}, 64'b0100);
    check_rsp("or32", 2, 64'hF00F, 0, 0, 0);
    release_rsp();
    issue(3'b011, 64'd5, 64'd5);
    check_rsp("sub32", 2, 64'd0, 1, 1, 0);
    release_rsp();
    issue(3'b011, 64'd3, 64'd5);
    check_rsp("sub32_neg", 2, 64'hFFFF_FFFE, 0, 0, 0);
    release_rsp();
    issue(3'b100, 64'h55, 64'h66);
    chk("ill_alu", {alu_a, 30'b0, alu_operation}, 64'd0);
    check_rsp("ill100", 1, 64'd0, 0, 1, 1);
    release_rsp();
    issue(3'b101, 64'h77, 64'h88);
    check_rsp("ill101", 1, 64'd0, 0, 1, 1);
    release_rsp();
    issue(3'b110, 64'h1234_5678_FFFF_FFFF, 64'h1);
    @(posedge clk) #1;
    chk("mid_hi_op", {62'b0, alu_operation}, 64'b10);
    #2 rst = 1;
    #1;
    chk("async_rst_alu", {alu_a, 28'b0, alu_operation, alu_binvert, alu_cin}, 64'd0);
    chk("async_rst_rsp", rsp_data | {60'b0, rsp_valid, rsp_carry, rsp_zero, rsp_err}, 64'd0);
    chk("async_rst_ready", {63'b0, cmd_ready}, 64'd0);
    @(negedge clk) rst = 0;
    issue(3'b010, 64'd3, 64'd4);
    check_rsp("post_rst", 2, 64'd7, 0, 0, 0);
    release_rsp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
